conv_engine_arbiter: RTL and testbench

Frame-level arbiter that shares one convolution engine among `R` input-stream requesters. The engine has an x valid/ready load port and a y valid/ready result port, consumes `N` samples per frame and returns `L = N-M+1` results. The arbiter grants the engine to one requester for a whole frame, forwards that requester's `N` samples, drains the `L` results to a shared output port tagged with the requester id, then re-arbitrates. It sits between the per-channel input buffers and the engine instance.

---
 rtl/conv_engine_arbiter_if.sv | 36 +++
 rtl/conv_engine_arbiter.sv | 130 +++++++++++++
 tb/tb_conv_engine_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_engine_arbiter_if.sv
// rtl/conv_engine_arbiter_if.sv - requester, engine and consumer handshake bundle for conv_engine_arbiter
interface conv_engine_arbiter_if #(
  parameter int R = 4,
  parameter int T = 16
);
  localparam int IDW = $clog2(R);

  logic [R*T-1:0] req_data;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [T-1:0]   eng_x_data;
  logic           eng_x_valid;
  logic           eng_x_ready;
  logic [T-1:0]   eng_y_data;
  logic           eng_y_valid;
  logic           eng_y_ready;
  logic [T-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  // slave is the arbiter's view; master is the surrounding buffers, engine and consumer
  modport slave (
    input  req_data, req_valid, eng_x_ready, eng_y_data, eng_y_valid, out_ready,
    output req_ready, eng_x_data, eng_x_valid, eng_y_ready, out_data, out_id, out_last,
           out_valid, busy
  );

  modport master (
    output req_data, req_valid, eng_x_ready, eng_y_data, eng_y_valid, out_ready,
    input  req_ready, eng_x_data, eng_x_valid, eng_y_ready, out_data, out_id, out_last,
           out_valid, busy
  );
endinterface

// File: rtl/conv_engine_arbiter.sv
// rtl/conv_engine_arbiter.sv - frame-level arbiter sharing one convolution engine among R requesters
// CONV_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module conv_engine_arbiter #(
  parameter int R = 4,
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_engine_arbiter_if.slave  bus
);
  localparam int L   = N - M + 1;
  localparam int IDW = $clog2(R);
  localparam int ICW = $clog2(N + 1);
  localparam int OCW = $clog2(L + 1);

  typedef enum logic [1:0] {IDLE, ARB, FEED, DRAIN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] g;
  logic [IDW-1:0] last;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [ICW-1:0] in_cnt;
  logic [OCW-1:0] out_cnt;
  logic           x_beat;
  logic           y_beat;
  logic           in_done;
  logic           out_done;

  assign x_beat   = (state == FEED) && bus.req_valid[g] && bus.eng_x_ready;
  assign y_beat   = (state == DRAIN) && bus.eng_y_valid && bus.out_ready;
  assign in_done  = (in_cnt == ICW'(N - 1));
  assign out_done = (out_cnt == OCW'(L - 1));

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
`ifdef CONV_ARB_FIXED_PRIO_EN
    for (int i = R - 1; i >= 0; i--) begin
      if (bus.req_valid[IDW'(i)]) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
      end
    end
`else
    // search starts just after the previous winner so every requester gets a turn
    for (int k = 1; k <= R; k++) begin
      int idx;
      idx = (int'(last) + k) % R;
      if (!win_found && bus.req_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req_valid) state_nxt = ARB;
      ARB:     state_nxt = win_found ? FEED : IDLE;
      FEED:    if (x_beat && in_done) state_nxt = DRAIN;
      DRAIN:   if (y_beat && out_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g       <= '0;
      last    <= IDW'(R - 1);
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          in_cnt  <= '0;
          out_cnt <= '0;
          if (win_found) begin
            g    <= win_id;
            last <= win_id;
          end
        end
        FEED:    if (x_beat) in_cnt <= in_cnt + 1'b1;
        DRAIN:   if (y_beat) out_cnt <= out_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // data paths are gated to zero outside their owning state so idle outputs read as reset values
  always_comb begin
    bus.req_ready   = '0;
    bus.eng_x_data  = '0;
    bus.eng_x_valid = 1'b0;
    bus.eng_y_ready = 1'b0;
    bus.out_data    = '0;
    bus.out_valid   = 1'b0;
    bus.out_last    = 1'b0;
    case (state)
      FEED: begin
        bus.req_ready[g] = bus.eng_x_ready;
        bus.eng_x_data   = bus.req_data[g*T +: T];
        bus.eng_x_valid  = bus.req_valid[g];
      end
      DRAIN: begin
        bus.out_data    = bus.eng_y_data;
        bus.out_valid   = bus.eng_y_valid;
        bus.eng_y_ready = bus.out_ready;
        bus.out_last    = out_done;
      end
      default: ;
    endcase
  end

  assign bus.out_id = g;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_conv_engine_arbiter.sv
// tb/tb_conv_engine_arbiter.sv - self-checking bench for conv_engine_arbiter with requester, engine and consumer models
module tb_conv_engine_arbiter;
  localparam int R = 4;
  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 16;
  localparam int L = N - M + 1;

  logic clk;
  logic reset;

  conv_engine_arbiter_if #(.R(R), .T(T)) bus ();

  conv_engine_arbiter #(.R(R), .N(N), .M(M), .T(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit [0:3][3:0]  fr;
    bit             bp;
    int             nf;
    bit [0:7][1:0]  order;
  } vec_t;

  typedef struct {
    logic [T-1:0] data;
    logic [1:0]   id;
    logic         last;
  } res_t;

  int            checks = 0;
  int            errors = 0;
  vec_t          vec[6];
  res_t          res_q[$];
  int            fr_left[R];
  int            fr_num[R];
  int            smp_k[R];
  int            e_phase, e_cnt, e_idx;
  logic [T-1:0]  e_buf[N];
  logic [T-1:0]  e_res[L];
  bit            bp;
  int            viol;
  int            frames_done;
  bit [0:7][1:0] cur_order;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [T-1:0] sample(int id, int f, int k);
    return T'((id << 8) | (f << 5) | (k + 1));
  endfunction

  function automatic logic [T-1:0] conv_ref(int id, int f, int j);
    logic [T-1:0] acc;
    acc = '0;
    for (int m = 0; m < M; m++) acc = acc + sample(id, f, j + m);
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_data    = '0;
    bus.req_valid   = '0;
    bus.eng_x_ready = 1'b0;
    bus.eng_y_data  = '0;
    bus.eng_y_valid = 1'b0;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < R; i++) begin
      fr_left[i] = 0;
      fr_num[i]  = 0;
      smp_k[i]   = 0;
    end
    e_phase = 0; e_cnt = 0; e_idx = 0; frames_done = 0; viol = 0;
    res_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < R; i++) begin
      bus.req_valid[i]        = (fr_left[i] > 0);
      bus.req_data[i*T +: T]  = sample(i, fr_num[i], smp_k[i]);
    end
    bus.eng_x_ready = (e_phase == 0) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
    if (e_phase == 1) begin
      bus.eng_y_valid = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.eng_y_data  = e_res[e_idx];
    end else begin
      // junk result while the engine is still loading must never reach the consumer
      bus.eng_y_valid = 1'b1;
      bus.eng_y_data  = 16'hdead;
    end
    bus.out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic observe();
    logic [1:0] owner;
    logic [T-1:0] acc;
    owner = cur_order[frames_done];
    if ((bus.req_ready & ~(4'b0001 << owner)) != 4'b0000) viol++;
    if (e_phase == 0 && (bus.out_valid || bus.eng_y_ready)) viol++;
    if (e_phase == 1 && (bus.eng_x_valid || bus.req_ready != 4'b0000)) viol++;
    for (int i = 0; i < R; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        smp_k[i]++;
        if (smp_k[i] == N) begin
          smp_k[i] = 0;
          fr_num[i]++;
          fr_left[i]--;
        end
      end
    end
    if (bus.out_valid && bus.out_ready)
      res_q.push_back('{data: bus.out_data, id: bus.out_id, last: bus.out_last});
    if (e_phase == 0) begin
      if (bus.eng_x_valid && bus.eng_x_ready) begin
        e_buf[e_cnt] = bus.eng_x_data;
        e_cnt++;
        if (e_cnt == N) begin
          for (int j = 0; j < L; j++) begin
            acc = '0;
            for (int m = 0; m < M; m++) acc = acc + e_buf[j + m];
            e_res[j] = acc;
          end
          e_phase = 1;
        end
      end
    end else if (bus.eng_y_valid && bus.eng_y_ready) begin
      e_idx++;
      if (e_idx == L) begin
        e_phase = 0; e_cnt = 0; e_idx = 0;
        frames_done++;
      end
    end
  endtask

  task automatic step();
    drive();
    #1;
    observe();
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {26'd0, bus.busy, bus.req_ready, bus.eng_x_valid, bus.eng_y_ready,
                         bus.out_valid, bus.out_last}, 32'd0);
    check({tag, "_id"}, {30'd0, bus.out_id}, 32'd0);
    check({tag, "_xdata"}, {16'd0, bus.eng_x_data}, 32'd0);
    check({tag, "_odata"}, {16'd0, bus.out_data}, 32'd0);
  endtask

  initial begin
    int cyc;
    int idx;
    int fcnt[R];

    vec[0] = '{fr: {4'd0, 4'd0, 4'd1, 4'd0}, bp: 1'b0, nf: 1,
               order: {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
`ifdef CONV_ARB_FIXED_PRIO_EN
    vec[1] = '{fr: {4'd2, 4'd1, 4'd1, 4'd1}, bp: 1'b0, nf: 5,
               order: {2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0}};
    vec[2] = '{fr: {4'd2, 4'd1, 4'd1, 4'd1}, bp: 1'b1, nf: 5,
               order: {2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0}};
    vec[5] = '{fr: {4'd3, 4'd0, 4'd0, 4'd2}, bp: 1'b1, nf: 5,
               order: {2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0}};
`else
    vec[1] = '{fr: {4'd2, 4'd1, 4'd1, 4'd1}, bp: 1'b0, nf: 5,
               order: {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0}};
    vec[2] = '{fr: {4'd2, 4'd1, 4'd1, 4'd1}, bp: 1'b1, nf: 5,
               order: {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0}};
    vec[5] = '{fr: {4'd3, 4'd0, 4'd0, 4'd2}, bp: 1'b1, nf: 5,
               order: {2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0}};
`endif
    vec[3] = '{fr: {4'd0, 4'd1, 4'd0, 4'd1}, bp: 1'b1, nf: 2,
               order: {2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vec[4] = '{fr: {4'd1, 4'd0, 4'd1, 4'd0}, bp: 1'b0, nf: 2,
               order: {2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};

    bp = 1'b0;
    cur_order = '0;
    @(negedge clk);
    do_reset();

    // reset values with live data on the inputs, valids low
    bus.req_data   = {4{16'ha5a5}};
    bus.eng_y_data = 16'h1234;
    #1;
    check_quiet("reset");

    // grant latency: request in IDLE, ARB next cycle, ready the cycle after
    bus.req_data[2*T +: T] = 16'h0001;
    bus.req_valid   = 4'b0100;
    bus.eng_x_ready = 1'b1;
    #1;
    check("lat_idle_busy", {31'd0, bus.busy}, 32'd0);
    tick(); #1;
    check("lat_arb", {27'd0, bus.busy, bus.req_ready}, {27'd0, 1'b1, 4'b0000});
    tick(); #1;
    check("lat_feed_ready", {28'd0, bus.req_ready}, {28'd0, 4'b0100});
    check("lat_feed_xvalid", {31'd0, bus.eng_x_valid}, 32'd1);
    for (int k = 0; k < 7; k++) begin
      bus.req_data[2*T +: T] = T'(k + 1);
      #1;
      check($sformatf("feed_x%0d", k), {16'd0, bus.eng_x_data}, k + 1);
      tick();
    end

    // reset after 7 samples, with request and engine ready still asserted
    reset = 1'b1;
    tick(); #1;
    check_quiet("midrst");
    reset = 1'b0;
    bus.req_valid = 4'b0010;
    tick();
    tick(); #1;
    check("midrst_grant1", {28'd0, bus.req_ready}, {28'd0, 4'b0010});

    // one-cycle request pulses are withdrawn by ARB and must not move last
    do_reset();
    bus.eng_x_ready = 1'b1;
    bus.req_valid   = 4'b1000;
    tick();
    bus.req_valid = 4'b0000;
    #1;
    check("wd3_arb", {27'd0, bus.busy, bus.req_ready}, {27'd0, 1'b1, 4'b0000});
    tick(); #1;
    check("wd3_idle", {27'd0, bus.busy, bus.req_ready}, 32'd0);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    tick(); #1;
    check("wd1_idle", {27'd0, bus.busy, bus.req_ready}, 32'd0);
    bus.req_valid = 4'b0111;
    tick();
    tick(); #1;
    check("wd_last_kept", {28'd0, bus.req_ready}, {28'd0, 4'b0001});

    for (int v = 0; v < 6; v++) begin
      do_reset();
      bp        = vec[v].bp;
      cur_order = vec[v].order;
      for (int i = 0; i < R; i++) begin
        fr_left[i] = int'(vec[v].fr[i]);
        fcnt[i]    = 0;
      end
      cyc = 0;
      while (res_q.size() < vec[v].nf * L && cyc < 4000) begin
        step();
        cyc++;
      end
      check($sformatf("v%0d_timeout", v), {31'd0, cyc < 4000}, 32'd1);
      check($sformatf("v%0d_nres", v), res_q.size(), vec[v].nf * L);
      for (int f = 0; f < vec[v].nf; f++) begin
        for (int j = 0; j < L; j++) begin
          idx = f * L + j;
          if (idx < res_q.size()) begin
            check($sformatf("v%0d_f%0d_r%0d_id", v, f, j), {30'd0, res_q[idx].id},
                  {30'd0, vec[v].order[f]});
            check($sformatf("v%0d_f%0d_r%0d_last", v, f, j), {31'd0, res_q[idx].last},
                  {31'd0, j == L - 1});
            check($sformatf("v%0d_f%0d_r%0d_data", v, f, j), {16'd0, res_q[idx].data},
                  {16'd0, conv_ref(vec[v].order[f], fcnt[vec[v].order[f]], j)});
          end
        end
        fcnt[vec[v].order[f]]++;
      end
      #1;
      check($sformatf("v%0d_busy_end", v), {31'd0, bus.busy}, 32'd0);
      check($sformatf("v%0d_frames", v), frames_done, vec[v].nf);
      check($sformatf("v%0d_ownership", v), viol, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
